// File: rtl/roberts_mdc_stream_source_pkg.sv
// Shared types for the Roberts MDC stream source: FSM state, control and status bundles.
// The struct widths follow the package CNT_LEN.
package multi_dataflow_roberts_mdc_package;

   localparam int CNT_LEN = 1024;
   localparam int CNT_W   = $clog2(CNT_LEN) + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND_SIZE = 2'd1,
      SEND_PEL  = 2'd2,
      DONE      = 2'd3
   } state_e;

   typedef struct packed {
      logic             start;
      logic             clear;
      logic [CNT_W-1:0] len;
   } ctrl_t;

   typedef struct packed {
      logic             busy;
      logic             done;
      logic [CNT_W-1:0] cnt;
   } flags_t;

endpackage

// File: rtl/roberts_mdc_stream_fifo2.sv
// Two-entry FIFO between the upstream pixel port and the pel stream.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module roberts_mdc_stream_fifo2 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  full_o,
   output logic                  empty_o
);

   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;
   logic       do_push;
   logic       do_pop;

   assign full_o  = (count_reg == 2'd2);
   assign empty_o = (count_reg == 2'd0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         logic [DATA_WIDTH-1:0] entry_reg;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               entry_reg <= '0;
            end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
               entry_reg <= data_i;
            end
         end
      end
   endgenerate

   // Stale entries stay hidden once the FIFO is empty or flushed.
   assign data_o = empty_o ? '0 : (rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg);

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/roberts_mdc_stream_source.sv
// Frame source: emits a size word, then forwards exactly len pixels from upstream
// through a 2-entry FIFO onto the pel stream, pulsing done_o at the end.
module roberts_mdc_stream_source
   import multi_dataflow_roberts_mdc_package::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_LEN    = multi_dataflow_roberts_mdc_package::CNT_LEN
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start_i,
   input  logic                        clear_i,
   input  logic [$clog2(CNT_LEN):0]    len_i,
   input  logic [DATA_WIDTH-1:0]       src_data_i,
   input  logic                        src_valid_i,
   output logic                        src_ready_o,
   output logic [DATA_WIDTH-1:0]       size_data_o,
   output logic [DATA_WIDTH/8-1:0]     size_strb_o,
   output logic                        size_valid_o,
   input  logic                        size_ready_i,
   output logic [DATA_WIDTH-1:0]       pel_data_o,
   output logic [DATA_WIDTH/8-1:0]     pel_strb_o,
   output logic                        pel_valid_o,
   input  logic                        pel_ready_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [$clog2(CNT_LEN):0]    cnt_o
);

   localparam int LEN_W = $clog2(CNT_LEN) + 1;

   state_e           state_reg;
   state_e           state_next;
   ctrl_t            ctrl;
   flags_t           flags;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] cnt_reg;
   logic [LEN_W-1:0] acc_reg;
   logic             start_ok;
   logic             last_pel;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;

   assign ctrl.start = start_i;
   assign ctrl.clear = clear_i;
   assign ctrl.len   = CNT_W'(len_i);

   // A zero-length start is dropped so it can never produce an empty frame.
   assign start_ok  = ctrl.start && !ctrl.clear && (state_reg == IDLE) && (ctrl.len != '0);
   assign fifo_push = src_valid_i && src_ready_o;
   assign fifo_pop  = pel_valid_o && pel_ready_i;
   assign last_pel  = fifo_pop && ((cnt_reg + LEN_W'(1)) == len_reg);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (ctrl.clear) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:      if (start_ok)     state_next = SEND_SIZE;
            SEND_SIZE: if (size_ready_i) state_next = SEND_PEL;
            SEND_PEL:  if (last_pel)     state_next = DONE;
            DONE:                        state_next = IDLE;
            default:                     state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      size_valid_o = (state_reg == SEND_SIZE);
      src_ready_o  = (state_reg == SEND_PEL) && !fifo_full && (acc_reg < len_reg);
      flags.busy   = (state_reg != IDLE);
      flags.done   = (state_reg == DONE);
      flags.cnt    = CNT_W'(cnt_reg);
   end

   // acc_reg counts pixels taken from upstream, cnt_reg pixels handed downstream.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         len_reg <= '0;
         cnt_reg <= '0;
         acc_reg <= '0;
      end else if (ctrl.clear) begin
         cnt_reg <= '0;
         acc_reg <= '0;
      end else if (start_ok) begin
         len_reg <= LEN_W'(ctrl.len);
         cnt_reg <= '0;
         acc_reg <= '0;
      end else begin
         if (fifo_pop)  cnt_reg <= cnt_reg + LEN_W'(1);
         if (fifo_push) acc_reg <= acc_reg + LEN_W'(1);
      end
   end

   roberts_mdc_stream_fifo2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (ctrl.clear),
      .push_i  (fifo_push),
      .data_i  (src_data_i),
      .pop_i   (fifo_pop),
      .data_o  (pel_data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign pel_valid_o = !fifo_empty;
   assign size_data_o = DATA_WIDTH'(len_reg);
   assign size_strb_o = '1;
   assign pel_strb_o  = '1;
   assign busy_o      = flags.busy;
   assign done_o      = flags.done;
   assign cnt_o       = LEN_W'(flags.cnt);

endmodule

// File: tb/tb_roberts_mdc_stream_source.sv
// Bench for roberts_mdc_stream_source: directed frames plus random traffic, all checked
// every cycle against a queue-based frame model.
module tb_roberts_mdc_stream_source;

   localparam int DW    = 32;
   localparam int LEN_W = 11;

   logic             clk = 1'b0;
   logic             rst_i, start_i, clear_i;
   logic [LEN_W-1:0] len_i;
   logic [DW-1:0]    src_data_i;
   logic             src_valid_i, src_ready_o;
   logic [DW-1:0]    size_data_o;
   logic [DW/8-1:0]  size_strb_o;
   logic             size_valid_o, size_ready_i;
   logic [DW-1:0]    pel_data_o;
   logic [DW/8-1:0]  pel_strb_o;
   logic             pel_valid_o, pel_ready_i;
   logic             busy_o, done_o;
   logic [LEN_W-1:0] cnt_o;

   always #5 clk = ~clk;

   roberts_mdc_stream_source #(.DATA_WIDTH(DW), .CNT_LEN(1024)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i), .len_i(len_i),
      .src_data_i(src_data_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
      .size_data_o(size_data_o), .size_strb_o(size_strb_o), .size_valid_o(size_valid_o),
      .size_ready_i(size_ready_i),
      .pel_data_o(pel_data_o), .pel_strb_o(pel_strb_o), .pel_valid_o(pel_valid_o),
      .pel_ready_i(pel_ready_i),
      .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Frame model: phase 0 idle, 1 size word pending, 2 pixels flowing, 3 done pulse.
   bit            mon_en = 0;
   int            phase = 0;
   int            m_len = 0, m_acc = 0, m_del = 0;
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] rx_log[$];
   int            done_seen = 0, acc_total = 0;
   longint        last_size = 0;
   bit            post_rst = 0;
   bit            saw_full_drop = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         check("busy", busy_o, phase != 0);
         check("size_valid", size_valid_o, phase == 1);
         if (phase == 1) check("size_data", size_data_o, m_len);
         check("done", done_o, phase == 3);
         check("cnt", cnt_o, m_del);
         check("pel_valid", pel_valid_o, m_q.size() != 0);
         if (m_q.size() != 0) check("pel_data", pel_data_o, m_q[0]);
         check("src_ready", src_ready_o, (phase == 2) && (m_q.size() < 2) && (m_acc < m_len));
         check("strb", {size_strb_o, pel_strb_o}, 64'hFF);
         if (post_rst) check("rst_data", {size_data_o, pel_data_o}, 0);
         if (done_o) done_seen++;

         if (rst_i) begin
            phase = 0; m_len = 0; m_acc = 0; m_del = 0; m_q.delete(); post_rst = 1;
         end else begin
            post_rst = 0;
            if (clear_i) begin
               phase = 0; m_acc = 0; m_del = 0; m_q.delete();
            end else begin
               bit pop, push;
               pop  = pel_valid_o && pel_ready_i && (m_q.size() != 0);
               push = src_valid_i && src_ready_o;
               if (phase == 2 && src_valid_i && !src_ready_o && m_q.size() == 2) saw_full_drop = 1;
               if (pop) begin
                  rx_log.push_back(m_q[0]);
                  void'(m_q.pop_front());
                  m_del++;
               end
               if (push) begin
                  if (m_acc >= m_len) check("over_accept", m_acc, m_len - 1);
                  m_q.push_back(src_data_i);
                  m_acc++;
                  acc_total++;
               end
               case (phase)
                  0: if (start_i && len_i != 0) begin
                        phase = 1; m_len = int'(len_i); m_acc = 0; m_del = 0;
                     end
                  1: if (size_ready_i) begin
                        phase = 2; last_size = size_data_o;
                     end
                  2: if (pop && m_del == m_len) phase = 3;
                  default: phase = 0;
               endcase
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start_i = 0; clear_i = 0; src_valid_i = 0; size_ready_i = 0; pel_ready_i = 0;
   endtask

   // pmode 0: pel_ready always 1, 1: toggling. stall: cycles of size_ready low.
   // clr_after > 0: pulse clear once that many pixels have been delivered.
   task automatic run_frame(input int len, input logic [DW-1:0] base, input int pmode,
                            input int stall, input int clr_after);
      int  nxt;
      int  d0;
      bit  hs;
      d0 = done_seen;
      start_i = 1; len_i = LEN_W'(len); tick(); start_i = 0;
      nxt = 0;
      for (int cyc = 0; cyc < 300 && done_seen == d0; cyc++) begin
         src_valid_i  = (nxt < len);
         src_data_i   = base + DW'(nxt);
         size_ready_i = (cyc >= stall);
         pel_ready_i  = (pmode == 0) ? 1'b1 : (cyc % 2 == 0);
         @(negedge clk);
         if (cyc < stall) begin
            check("size_hold", size_data_o, len);
            check("no_accept", src_ready_o, 0);
         end
         hs = src_valid_i && src_ready_o;
         tick();
         if (hs) nxt++;
         if (clr_after > 0 && rx_log.size() == clr_after) begin
            idle_inputs();
            clear_i = 1; tick(); clear_i = 0;
            break;
         end
      end
      if (clr_after == 0) check("frame_done", done_seen - d0, 1);
      idle_inputs();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      rst_i = 1; len_i = 0; src_data_i = 0;
      idle_inputs();
      tick(); tick();
      mon_en = 1;
      check("reset_busy", busy_o, 0);
      check("reset_cnt", cnt_o, 0);
      check("reset_pel_valid", pel_valid_o, 0);
      check("reset_size_data", size_data_o, 0);
      rst_i = 0; tick();

      // len 4, all ready, pixels 0x11..0x14
      rx_log.delete(); done_seen = 0;
      run_frame(4, 32'h11, 0, 0, 0);
      check("t1_size_word", last_size, 4);
      check("t1_done_pulses", done_seen, 1);
      check("t1_cnt", cnt_o, 4);
      check("t1_rx_count", rx_log.size(), 4);
      if (rx_log.size() == 4) begin
         check("t1_px0", rx_log[0], 32'h11);
         check("t1_px3", rx_log[3], 32'h14);
         for (int i = 0; i < 4; i++) check("t1_px", rx_log[i], 32'h11 + i);
      end

      // len 3 with the size word stalled for 5 cycles
      rx_log.delete();
      run_frame(3, 32'h21, 0, 5, 0);
      check("t2_cnt", cnt_o, 3);
      check("t2_rx_count", rx_log.size(), 3);

      // len 8, pel_ready toggling: FIFO fills, order kept
      rx_log.delete(); saw_full_drop = 0; a0 = acc_total;
      run_frame(8, 32'hA0, 1, 0, 0);
      check("t3_cnt", cnt_o, 8);
      check("t3_accepted", acc_total - a0, 8);
      check("t3_ready_dropped", saw_full_drop, 1);
      for (int i = 0; i < 8 && i < rx_log.size(); i++) check("t3_order", rx_log[i], 32'hA0 + i);

      // clear after 2 of 6, then a clean len-2 frame
      rx_log.delete(); done_seen = 0;
      run_frame(6, 32'h60, 0, 0, 2);
      check("t4_busy", busy_o, 0);
      check("t4_cnt", cnt_o, 0);
      check("t4_no_done", done_seen, 0);
      run_frame(2, 32'h70, 0, 0, 0);
      check("t4b_cnt", cnt_o, 2);
      check("t4b_done", done_seen, 1);

      // ignored starts: zero length, and start while busy
      start_i = 1; len_i = 0; tick(); start_i = 0;
      check("t5_len0_busy", busy_o, 0);
      check("t5_len0_cnt", cnt_o, 2);
      start_i = 1; len_i = 5; tick();
      check("t5_busy", busy_o, 1);
      len_i = 9; tick(); start_i = 0;
      check("t5_busy_hold", busy_o, 1);
      check("t5_size_kept", size_data_o, 5);
      check("t5_cnt_kept", cnt_o, 0);
      clear_i = 1; tick(); clear_i = 0; tick();

      // reset mid-frame with the FIFO full
      start_i = 1; len_i = 6; tick(); start_i = 0;
      size_ready_i = 1; pel_ready_i = 0; src_valid_i = 1;
      for (int i = 0; i < 6; i++) begin
         src_data_i = 32'h40 + i;
         tick();
      end
      check("t6_full_valid", pel_valid_o, 1);
      check("t6_full_ready", src_ready_o, 0);
      rst_i = 1; tick();
      check("t6_rst_busy", busy_o, 0);
      check("t6_rst_pel_valid", pel_valid_o, 0);
      check("t6_rst_src_ready", src_ready_o, 0);
      check("t6_rst_size_valid", size_valid_o, 0);
      check("t6_rst_pel_data", pel_data_o, 0);
      check("t6_rst_cnt", cnt_o, 0);
      rst_i = 0; idle_inputs(); tick();
      check("t6_after_pel_valid", pel_valid_o, 0);
      check("t6_after_done", done_o, 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_i        = ($urandom_range(0, 499) == 0);
         clear_i      = ($urandom_range(0, 199) == 0);
         start_i      = ($urandom_range(0, 5) == 0);
         len_i        = LEN_W'($urandom_range(0, 12));
         src_valid_i  = ($urandom_range(0, 3) != 0);
         src_data_i   = $urandom;
         size_ready_i = 1'($urandom_range(0, 1));
         pel_ready_i  = ($urandom_range(0, 4) != 0);
         tick();
      end
      rst_i = 0; idle_inputs();
      clear_i = 1; tick(); clear_i = 0; tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/roberts_mdc_stream_source.md
ROBERTS_MDC_STREAM_SOURCE -- requirements
Module: roberts_mdc_stream_source

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the size and pixel stream data.
REQ-002 SHALL have parameter CNT_LEN, default 1024, meaning the maximum frame length in pixels.
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 start_i  in  1  one-cycle frame start request.
REQ-006 clear_i  in  1  synchronous soft clear.
REQ-007 len_i  in  $clog2(CNT_LEN)+1  frame length in pixels, sampled on an accepted start.
REQ-008 src_data_i / src_valid_i / src_ready_o  in/in/out  DATA_WIDTH/1/1  upstream pixel port, valid/ready protocol.
REQ-009 size_data_o / size_strb_o / size_valid_o / size_ready_i  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  HWPE source stream carrying the size word.
REQ-010 pel_data_o / pel_strb_o / pel_valid_o / pel_ready_i  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  HWPE source stream carrying the pixels.
REQ-011 busy_o  out  1  high in any state other than IDLE.
REQ-012 done_o  out  1  one-cycle pulse at frame completion.
REQ-013 cnt_o  out  $clog2(CNT_LEN)+1  pixels delivered on pel_* in the current or last frame.

Function
REQ-014 The block SHALL implement the FSM states IDLE, SEND_SIZE, SEND_PEL and DONE.
REQ-015 In IDLE, start_i=1 with len_i>0 SHALL latch len_i, zero cnt_o and move to SEND_SIZE on the next cycle.
REQ-016 In IDLE, start_i with len_i=0 SHALL be ignored, with no state change and no done_o.
REQ-017 start_i SHALL be ignored in any state other than IDLE.
REQ-018 In SEND_SIZE, size_valid_o SHALL be 1 and size_data_o SHALL equal the latched length, zero-extended.
REQ-019 size_data_o SHALL be held stable until size_valid_o&size_ready_i; the block SHALL then move to SEND_PEL.
REQ-020 size_valid_o SHALL be 0 in all other states.
REQ-021 Upstream pixels SHALL pass through a 2-entry FIFO; pel_valid_o SHALL equal FIFO not empty; pel_data_o SHALL be the FIFO head.
REQ-022 src_ready_o SHALL be 1 only in SEND_PEL, with the FIFO not full and accepted pixels < latched length.
REQ-023 No pixel beyond the latched length SHALL be accepted.
REQ-024 Push and pop in the same cycle SHALL be legal at any occupancy the FIFO allows, including push while full when a pop occurs.
REQ-025 pel_data_o and pel_valid_o SHALL stay stable while pel_valid_o&~pel_ready_i.
REQ-026 Each pel handshake SHALL increment cnt_o by 1 in the following cycle.
REQ-027 The handshake that brings cnt_o to the latched length SHALL move the FSM to DONE.
REQ-028 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-029 cnt_o SHALL hold its value in IDLE until clear_i or the next accepted start.
REQ-030 size_strb_o and pel_strb_o SHALL be all ones at all times.
REQ-031 clear_i SHALL, in any state, return the FSM to IDLE, flush the FIFO and zero cnt_o next cycle, without a done_o pulse.
REQ-032 clear_i SHALL have priority over start_i in the same cycle.

Reset
REQ-033 rst_i=1 at a clock edge SHALL force state IDLE, FIFO empty, latched length 0 and cnt_o 0.
REQ-034 During and after reset, all valid, ready, busy_o and done_o outputs SHALL be 0 and size_data_o/pel_data_o SHALL be 0.
REQ-035 Reset mid-frame SHALL discard buffered pixels, and no handshake SHALL occur in the cycle after reset.

Structure
REQ-036 The FSM state enum, a ctrl struct (start, clear, len) and a flags struct (busy, done, cnt) SHALL be placed in the multi_dataflow_roberts_mdc_package, alongside the CNT_LEN constant.
REQ-037 The 2-entry FIFO SHALL be the single sub-module roberts_mdc_stream_fifo2 (DATA_WIDTH parameter, push/pop/full/empty).

Verification
REQ-038 len=4, size_ready and pel_ready always 1, pixels 0x11..0x14 back-to-back -> size word 4, pel stream 0x11,0x12,0x13,0x14, done_o one pulse, cnt_o=4.
REQ-039 len=3, size_ready low for 5 cycles -> size_data_o stays 3 and no pixel is accepted until the size handshake.
REQ-040 len=8, pel_ready toggling 1/0 every cycle, src_valid always 1 -> order is preserved, src_ready_o drops when the FIFO is full, exactly 8 pixels are accepted, cnt_o=8.
REQ-041 clear_i after 2 of 6 pixels -> IDLE next cycle, cnt_o=0, no done_o; a following start with len=2 completes normally.
REQ-042 start with len=0, and start while busy -> both ignored, busy_o and cnt_o unchanged.
REQ-043 rst_i asserted mid-SEND_PEL with the FIFO full -> all outputs 0 next cycle and the FIFO empty.
